// File: rtl/cic_pkg.sv
// Shared constants and state encoding for the CIC decimator controller.
package cic_pkg;

    localparam int DEF_W     = 24;
    localparam int DEF_ORDER = 2;
    localparam int DEF_RATIO = 4;
    localparam int MIN_RATIO = 2;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t FLUSH  = 2'd1;
    localparam state_t SETTLE = 2'd2;
    localparam state_t RUN    = 2'd3;

endpackage

// File: rtl/cic_phase_gen.sv
// Reloadable decimation phase counter: emits the comb strobe every R cycles
// and counts strobes since the last load, saturating at ORDER.
module cic_phase_gen
    import cic_pkg::*;
#(
    parameter int RW    = 8,
    parameter int ORDER = DEF_ORDER,
    parameter int CW    = $clog2(ORDER + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          run,
    input  logic [RW-1:0] ratio,
    output logic          strobe,
    output logic [CW-1:0] count
);

    logic [RW-1:0] phase;

    assign strobe = run && (phase == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= '0;
            count <= '0;
        end else if (load) begin
            phase <= ratio - RW'(1);
            count <= '0;
        end else if (run) begin
            if (phase == '0) begin
                phase <= ratio - RW'(1);
                if (count != CW'(ORDER))
                    count <= count + CW'(1);
            end else begin
                phase <= phase - RW'(1);
            end
        end
    end

endmodule

// File: rtl/cic_ctrl.sv
// CIC decimator sequencer: ratio config, flush/settle/run FSM, output stream.
// Optional drop counter port enabled by defining CIC_CTRL_DROPCNT_EN.
module cic_ctrl
    import cic_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int RW    = 8,
    parameter int ORDER = DEF_ORDER
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          cfg_valid,
    input  logic [RW-1:0] cfg_ratio,
    output logic          cfg_ready,
    output logic          int_en,
    output logic          comb_en,
    output logic          dp_clear,
    input  logic [W-1:0]  dp_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          overrun,
    output logic          busy
`ifdef CIC_CTRL_DROPCNT_EN
    ,
    output logic [15:0]   drop_count
`endif
);

    localparam int CW = $clog2(ORDER + 1);
    localparam logic [RW-1:0] RATIO_RST = RW'(DEF_RATIO);
    localparam logic [RW-1:0] RATIO_MIN = RW'(MIN_RATIO);

    state_t        state;
    logic [RW-1:0] ratio;
    logic [CW-1:0] count;
    logic          active;
    logic          strobe;
    logic          last_settle;
    logic          cap_pend;
    logic          capture;
    logic          drop;
    logic          xfer;

    assign active      = enable && (state == SETTLE || state == RUN);
    assign int_en      = active;
    assign comb_en     = strobe;
    assign dp_clear    = (state == FLUSH);
    assign cfg_ready   = (state == IDLE) && !reset;
    assign busy        = (state != IDLE);
    assign last_settle = strobe && (count == CW'(ORDER - 1));
    // Strobe in t makes dp_data valid in t+1; dropping enable cancels it.
    assign capture     = cap_pend && enable && (state == RUN);
    assign drop        = capture && out_valid && !out_ready;
    assign xfer        = out_valid && out_ready;

    cic_phase_gen #(
        .RW    (RW),
        .ORDER (ORDER),
        .CW    (CW)
    ) u_phase (
        .clk    (clk),
        .reset  (reset),
        .load   (state == FLUSH),
        .run    (active),
        .ratio  (ratio),
        .strobe (strobe),
        .count  (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ratio <= RATIO_RST;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cfg_valid)
                        ratio <= (cfg_ratio < RATIO_MIN) ? RATIO_MIN : cfg_ratio;
                    else if (enable)
                        state <= FLUSH;
                end
                FLUSH: state <= SETTLE;
                SETTLE: begin
                    if (!enable)
                        state <= IDLE;
                    else if (last_settle)
                        state <= RUN;
                end
                RUN: begin
                    if (!enable)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_pend  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overrun   <= 1'b0;
        end else begin
            cap_pend <= strobe && (state == RUN);
            if (drop) begin
                overrun <= 1'b1;
            end else if (capture) begin
                out_data  <= dp_data;
                out_valid <= 1'b1;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef CIC_CTRL_DROPCNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            drop_count <= '0;
        else if (drop && drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_cic_ctrl.sv
// Directed self-checking bench for cic_ctrl (hand-derived strobe/capture timing).
`timescale 1ns/1ps
module tb_cic_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        cfg_valid;
    logic [7:0]  cfg_ratio;
    logic        cfg_ready;
    logic        int_en;
    logic        comb_en;
    logic        dp_clear;
    logic [23:0] dp_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        overrun;
    logic        busy;
`ifdef CIC_CTRL_DROPCNT_EN
    logic [15:0] drop_count;
    logic [15:0] dc_h [64];
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic        ov_h  [64];
    logic        ovr_h [64];
    logic [23:0] od_h  [64];
    logic [23:0] dp_h  [64];
    logic [23:0] held;

    cic_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_ratio  (cfg_ratio),
        .cfg_ready  (cfg_ready),
        .int_en     (int_en),
        .comb_en    (comb_en),
        .dp_clear   (dp_clear),
        .dp_data    (dp_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .overrun    (overrun),
        .busy       (busy)
`ifdef CIC_CTRL_DROPCNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Advance one cycle; a fresh dp_data value is driven every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        dp_data = 24'h5A0000 + 24'(cyc);
    endtask

    // Caller sits in the FLUSH cycle (k=0); runs k=1..n relative to it.
    task automatic go(input int n, input int per, input logic [63:0] rdy);
        for (int k = 1; k <= n; k++) begin
            tick();
            out_ready = rdy[k];
            chk($sformatf("comb_en k=%0d", k), 32'(comb_en),
                32'((k % per) == 0));
            chk($sformatf("int_en k=%0d", k), 32'(int_en), 32'd1);
            ov_h[k]  = out_valid;
            ovr_h[k] = overrun;
            od_h[k]  = out_data;
            dp_h[k]  = dp_data;
`ifdef CIC_CTRL_DROPCNT_EN
            dc_h[k]  = drop_count;
`endif
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " busy"},      32'(busy),      32'd0);
        chk({tag, " int_en"},    32'(int_en),    32'd0);
        chk({tag, " comb_en"},   32'(comb_en),   32'd0);
        chk({tag, " dp_clear"},  32'(dp_clear),  32'd0);
        chk({tag, " cfg_ready"}, 32'(cfg_ready), 32'd0);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " out_data"},  32'(out_data),  32'd0);
        chk({tag, " overrun"},   32'(overrun),   32'd0);
`ifdef CIC_CTRL_DROPCNT_EN
        chk({tag, " drop_count"}, 32'(drop_count), 32'd0);
`endif
    endtask

    task automatic chk_flush(input string tag);
        chk({tag, " dp_clear"},  32'(dp_clear),  32'd1);
        chk({tag, " int_en"},    32'(int_en),    32'd0);
        chk({tag, " cfg_ready"}, 32'(cfg_ready), 32'd0);
        chk({tag, " busy"},      32'(busy),      32'd1);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
        cfg_ratio = 8'd0; out_ready = 1'b0; dp_data = 24'h0;
        tick();
        tick();
        chk_reset_outs("rst");

        // R=4 default run, consumer stalled, drain once at k=22
        reset = 1'b0;
        #1;
        chk("idle cfg_ready", 32'(cfg_ready), 32'd1);
        enable = 1'b1;
        tick();
        chk_flush("flush1");
        go(24, 4, 64'd1 << 22);
        chk("r4 ov k13",  32'(ov_h[13]),  32'd0);
        chk("r4 ov k14",  32'(ov_h[14]),  32'd1);
        chk("r4 od k14",  32'(od_h[14]),  32'(dp_h[13]));
        chk("r4 ovr k17", 32'(ovr_h[17]), 32'd0);
        chk("r4 ovr k18", 32'(ovr_h[18]), 32'd1);
        chk("r4 od k22",  32'(od_h[22]),  32'(dp_h[13]));
        chk("r4 ov k23",  32'(ov_h[23]),  32'd0);
`ifdef CIC_CTRL_DROPCNT_EN
        chk("dc k18", 32'(dc_h[18]), 32'd1);
        chk("dc k21", 32'(dc_h[21]), 32'd1);
        chk("dc k22", 32'(dc_h[22]), 32'd2);
`endif
        held = dp_h[13];

        // Drop enable in RUN while a capture is pending
        tick();
        enable = 1'b0;
        #1;
        chk("run drop int_en",  32'(int_en),  32'd0);
        chk("run drop comb_en", 32'(comb_en), 32'd0);
        chk("run drop busy",    32'(busy),    32'd1);
        tick();
        chk("run drop idle",     32'(busy),      32'd0);
        chk("run drop no cap",   32'(out_valid), 32'd0);
        chk("run drop out_data", 32'(out_data),  32'(held));
        chk("run drop overrun",  32'(overrun),   32'd1);

        // Re-enable: flush again and discard ORDER strobes
        enable = 1'b1;
        tick();
        chk_flush("flush2");
        go(14, 4, 64'd0);
        chk("reen ov k12", 32'(ov_h[12]), 32'd0);
        chk("reen ov k13", 32'(ov_h[13]), 32'd0);
        chk("reen ov k14", 32'(ov_h[14]), 32'd1);
        chk("reen od k14", 32'(od_h[14]), 32'(dp_h[13]));
        held = dp_h[13];
        enable = 1'b0;
        tick();

        // Drop enable mid-SETTLE; the held sample survives IDLE
        enable = 1'b1;
        tick();
        chk_flush("flush3");
        go(5, 4, 64'd0);
        tick();
        enable = 1'b0;
        #1;
        chk("settle drop int_en",  32'(int_en),  32'd0);
        chk("settle drop comb_en", 32'(comb_en), 32'd0);
        chk("settle drop busy",    32'(busy),    32'd1);
        tick();
        chk("settle drop idle",  32'(busy),      32'd0);
        chk("idle keeps valid",  32'(out_valid), 32'd1);
        chk("idle keeps data",   32'(out_data),  32'(held));

        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Ratios 0 and 1 clamp to 2; back-to-back transfers on capture cycles
        cfg_valid = 1'b1; cfg_ratio = 8'd0;
        tick();
        cfg_ratio = 8'd1; enable = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        chk_flush("flush4");
        go(16, 2, 64'h0000_0000_0000_AA00);
        chk("r2 ov k7", 32'(ov_h[7]), 32'd0);
        for (int k = 8; k <= 16; k++) begin
            chk($sformatf("r2 ov k%0d", k), 32'(ov_h[k]), 32'd1);
            chk($sformatf("r2 od k%0d", k), 32'(od_h[k]),
                32'(dp_h[(k % 2 == 0) ? k - 1 : k - 2]));
            chk($sformatf("r2 ovr k%0d", k), 32'(ovr_h[k]), 32'd0);
        end

        // Ratio write during RUN is ignored
        cfg_valid = 1'b1; cfg_ratio = 8'd8;
        #1;
        chk("run cfg_ready", 32'(cfg_ready), 32'd0);
        go(6, 2, 64'd0);
        cfg_valid = 1'b0;

        // Reset mid-RUN, then the ratio is back to 4
        reset = 1'b1;
        tick();
        chk_reset_outs("rst run");
        reset = 1'b0;
        tick();
        chk_flush("flush5");
        go(8, 4, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
